// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the program-counter / return-address
//               stack unit. Provides the control-flow command encoding used by
//               the decode/control unit and the fetch-stage PC logic.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Width of the control-flow command field
  localparam int OP_W = 3;

  // Command encoding; values 5-7 are reserved and execute as OP_SEQ
  localparam logic [OP_W-1:0] OP_SEQ  = 3'd0;
  localparam logic [OP_W-1:0] OP_JABS = 3'd1;
  localparam logic [OP_W-1:0] OP_JREL = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL = 3'd3;
  localparam logic [OP_W-1:0] OP_RET  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pc_ras_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_if
// Description : Control/status bundle between the decode/control unit (master)
//               and the fetch-stage PC unit (slave).
//   en        : 1 = execute op this cycle, 0 = stall
//   op        : control-flow command (pc_pkg encoding)
//   target    : JABS/CALL destination, JREL signed offset
//   err_clr   : clears sticky error flags
//   pc        : current fetch address
//   ras_count : valid return-address stack entries
//   ras_full  : stack holds RAS_DEPTH entries
//   ras_empty : stack holds no entries
//   err_ovf   : sticky, CALL issued while stack full
//   err_unf   : sticky, RET issued while stack empty
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_ras_if #(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic                   en;
  logic [pc_pkg::OP_W-1:0] op;
  logic [AW-1:0]          target;
  logic                   err_clr;
  logic [AW-1:0]          pc;
  logic [CW-1:0]          ras_count;
  logic                   ras_full;
  logic                   ras_empty;
  logic                   err_ovf;
  logic                   err_unf;

  modport master (
    output en, op, target, err_clr,
    input  pc, ras_count, ras_full, ras_empty, err_ovf, err_unf
  );

  modport slave (
    input  en, op, target, err_clr,
    output pc, ras_count, ras_full, ras_empty, err_ovf, err_unf
  );

endinterface
`default_nettype wire

// File: rtl/ras_lifo.sv
`default_nettype none
// ============================================================================
// Module      : ras_lifo
// Description : Circular return-address stack. A push while full overwrites
//               the oldest entry and becomes the new top; a pop while empty is
//               ignored. Storage is not reset; only counted entries are valid.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   push      : write push_data as new top
//   pop       : discard top entry (push has priority if both asserted)
//   push_data : address to push
//   top_data  : current top entry (meaningful only when not empty)
//   count     : number of valid entries
//   full      : count == DEPTH
//   empty     : count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module ras_lifo #(
  parameter int AW    = 16,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_top_up;
  logic          w_do_pop;

  // DEPTH is a power of two, so the pointer wraps naturally; the slot above
  // the top after a full wrap is exactly the oldest entry.
  assign w_top_up = r_top + 1'b1;
  assign w_do_pop = pop && !push && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_top <= w_top_up;
      if (r_count != c_depth) begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_do_pop) begin
      r_top   <= r_top - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[w_top_up] <= push_data;
    end
  end

  assign top_data = r_mem[r_top];
  assign count    = r_count;
  assign full     = (r_count == c_depth);
  assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_unit
// Description : Fetch-stage program counter with sequential advance, absolute
//               and relative jumps, and CALL/RET through a return-address
//               stack. One command per enabled cycle, result visible next
//               cycle. All PC arithmetic wraps modulo 2^AW.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   bus       : pc_ras_if slave - command inputs, pc/stack/error status
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int            AW        = 16,
  parameter int            INC       = 2,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int            RAS_DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  pc_ras_if.slave  bus
);

  localparam int            CW    = $clog2(RAS_DEPTH + 1);
  localparam logic [AW-1:0] c_inc = AW'(INC);

  logic [AW-1:0] r_pc;
  logic          r_err_ovf;
  logic          r_err_unf;

  logic [AW-1:0] w_pc_seq;
  logic [AW-1:0] w_pc_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_evt;
  logic          w_unf_evt;
  logic [AW-1:0] w_ras_top;
  logic [CW-1:0] w_ras_count;
  logic          w_ras_full;
  logic          w_ras_empty;

  assign w_pc_seq = r_pc + c_inc;

  // Next-pc selection and stack control; everything is gated by en so a
  // stalled cycle leaves the stack and the flags untouched.
  always_comb begin
    w_pc_nxt  = w_pc_seq;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (bus.en) begin
      case (bus.op)
        OP_JABS: w_pc_nxt = bus.target;
        OP_JREL: w_pc_nxt = r_pc + bus.target;
        OP_CALL: begin
          w_pc_nxt  = bus.target;
          w_push    = 1'b1;
          w_ovf_evt = w_ras_full;
        end
        OP_RET: begin
          // Empty stack: fall through to a sequential advance
          if (w_ras_empty) begin
            w_unf_evt = 1'b1;
          end else begin
            w_pc_nxt = w_ras_top;
            w_pop    = 1'b1;
          end
        end
        default: w_pc_nxt = w_pc_seq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VEC;
    end else if (bus.en) begin
      r_pc <= w_pc_nxt;
    end
  end

  // A new error event takes precedence over err_clr in the same cycle;
  // err_clr works regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_err_ovf <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_ovf <= 1'b0;
      end
      if (w_unf_evt) begin
        r_err_unf <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_unf <= 1'b0;
      end
    end
  end

  ras_lifo #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_seq),
    .top_data  (w_ras_top),
    .count     (w_ras_count),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  assign bus.pc        = r_pc;
  assign bus.ras_count = w_ras_count;
  assign bus.ras_full  = w_ras_full;
  assign bus.ras_empty = w_ras_empty;
  assign bus.err_ovf   = r_err_ovf;
  assign bus.err_unf   = r_err_unf;

endmodule
`default_nettype wire
